// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester, response and memory-port signals around the burst arbiter.
// master: instruction/data engines plus the memory side; slave: the arbiter itself.
interface mem_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wnext;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_done;

    logic        mem_r;
    logic        mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
               mem_r, mem_w, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
               mem_r, mem_w, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one burst memory port between the I-side refill and D-side refill/writeback
// engines: alternating grant under contention, fixed-length bursts, timeout abort.
module mem_bus_arbiter #(
    parameter int unsigned BURST_LOG2 = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);
    localparam int unsigned BW  = BURST_LOG2;
    localparam int unsigned OFS = BURST_LOG2 + 2;
    localparam int unsigned AW  = 32 - OFS;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_BEAT  = {BW{1'b1}};
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [BW-1:0] beat;
    logic [TW-1:0] timer;
    logic [AW-1:0] base_blk;
    logic          we_q;
    logic          last_grant_d;
    logic          mem_r_q;
    logic          mem_w_q;
    logic          i_done_q;
    logic          d_done_q;
    logic          bus_err_q;

    // Grant decision: D wins a tie unless it won the previous grant.
    logic          grant_d_c;
    logic          grant_we_c;
    logic [AW-1:0] grant_blk_c;
    logic          unused_addr_bits;

    assign grant_d_c   = bus.d_req && (!bus.i_req || !last_grant_d);
    assign grant_we_c  = grant_d_c && bus.d_we;
    assign grant_blk_c = grant_d_c ? bus.d_addr[31:OFS] : bus.i_addr[31:OFS];
    assign unused_addr_bits = ^{bus.i_addr[OFS-1:0], bus.d_addr[OFS-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            timer        <= '0;
            base_blk     <= '0;
            we_q         <= 1'b0;
            last_grant_d <= 1'b0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state        <= grant_d_c ? BUSY_D : BUSY_I;
                        base_blk     <= grant_blk_c;
                        we_q         <= grant_we_c;
                        last_grant_d <= grant_d_c;
                        beat         <= '0;
                        timer        <= '0;
                        mem_r_q      <= !grant_we_c;
                        mem_w_q      <= grant_we_c;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        beat  <= beat + BW'(1);
                        timer <= '0;
                        if (beat == LAST_BEAT) begin
                            state    <= DONE;
                            mem_r_q  <= 1'b0;
                            mem_w_q  <= 1'b0;
                            i_done_q <= (state == BUSY_I);
                            d_done_q <= (state == BUSY_D);
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Memory stopped answering: abandon the burst and flag it.
                        state     <= DONE;
                        timer     <= '0;
                        mem_r_q   <= 1'b0;
                        mem_w_q   <= 1'b0;
                        i_done_q  <= (state == BUSY_I);
                        d_done_q  <= (state == BUSY_D);
                        bus_err_q <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beat steering: read data goes only to the owner, in the cycle memory delivers it.
    logic busy_c;
    logic i_beat_c;
    logic d_beat_c;

    assign busy_c   = (state == BUSY_I) || (state == BUSY_D);
    assign i_beat_c = (state == BUSY_I) && bus.mem_ready;
    assign d_beat_c = (state == BUSY_D) && bus.mem_ready;

    assign bus.i_rvalid = i_beat_c;
    assign bus.i_rdata  = i_beat_c ? bus.mem_rdata : '0;
    assign bus.d_rvalid = d_beat_c && !we_q;
    assign bus.d_rdata  = (d_beat_c && !we_q) ? bus.mem_rdata : '0;
    assign bus.d_wnext  = d_beat_c && we_q;

    assign bus.mem_r     = mem_r_q;
    assign bus.mem_w     = mem_w_q;
    assign bus.mem_addr  = busy_c ? {base_blk, beat, 2'b00} : '0;
    assign bus.mem_wdata = ((state == BUSY_D) && we_q) ? bus.d_wdata : '0;

    assign bus.i_done  = i_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed per-cycle vector table for mem_bus_arbiter (4-word bursts, TIMEOUT=8),
// followed by a stalled-beat burst checked beat by beat.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .BURST_LOG2 (2),
        .TIMEOUT    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        mem_r;
        logic        mem_w;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        i_rvalid;
        logic [31:0] i_rdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        d_wnext;
        logic        i_done;
        logic        d_done;
        logic        bus_err;
    } out_t;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic out_t observe();
        out_t o;
        o.mem_r     = bus.mem_r;
        o.mem_w     = bus.mem_w;
        o.mem_addr  = bus.mem_addr;
        o.mem_wdata = bus.mem_wdata;
        o.i_rvalid  = bus.i_rvalid;
        o.i_rdata   = bus.i_rdata;
        o.d_rvalid  = bus.d_rvalid;
        o.d_rdata   = bus.d_rdata;
        o.d_wnext   = bus.d_wnext;
        o.i_done    = bus.i_done;
        o.d_done    = bus.d_done;
        o.bus_err   = bus.bus_err;
        return o;
    endfunction

    // Expected-output builders
    function automatic out_t e_idle();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t e_ri(logic [31:0] a, logic rdy, logic [31:0] dat);
        out_t o;
        o          = '0;
        o.mem_r    = 1'b1;
        o.mem_addr = a;
        o.i_rvalid = rdy;
        o.i_rdata  = rdy ? dat : 32'h0;
        return o;
    endfunction

    function automatic out_t e_rd(logic [31:0] a, logic rdy, logic [31:0] dat);
        out_t o;
        o          = '0;
        o.mem_r    = 1'b1;
        o.mem_addr = a;
        o.d_rvalid = rdy;
        o.d_rdata  = rdy ? dat : 32'h0;
        return o;
    endfunction

    function automatic out_t e_wr(logic [31:0] a, logic rdy, logic [31:0] wd);
        out_t o;
        o           = '0;
        o.mem_w     = 1'b1;
        o.mem_addr  = a;
        o.mem_wdata = wd;
        o.d_wnext   = rdy;
        return o;
    endfunction

    function automatic out_t e_done(logic i, logic d, logic err);
        out_t o;
        o         = '0;
        o.i_done  = i;
        o.d_done  = d;
        o.bus_err = err;
        return o;
    endfunction

    task automatic row(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] rd,
                       input out_t e);
        vec_t v;
        v.rst = r;   v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = wd;
        v.mem_ready = rdy; v.mem_rdata = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nbeat;
        int ndone;
        int nbad;

        // I read: base 0x0 from address 0x8
        row(0,1,32'h8, 0,0,0,0, 0,0, e_idle());
        row(0,1,32'h8, 0,0,0,0, 1,32'h11111111, e_ri(32'h0,1,32'h11111111));
        row(0,1,32'h8, 0,0,0,0, 1,32'h22222222, e_ri(32'h4,1,32'h22222222));
        row(0,1,32'h8, 0,0,0,0, 1,32'h33333333, e_ri(32'h8,1,32'h33333333));
        row(0,1,32'h8, 0,0,0,0, 1,32'h44444444, e_ri(32'hC,1,32'h44444444));
        row(0,0,32'h8, 0,0,0,0, 0,0, e_done(1,0,0));
        row(0,0,0, 0,0,0,0, 1,32'hDEADBEEF, e_idle());
        // D writeback; d_we/d_addr wiggle after grant must not matter
        row(0,0,0, 1,1,32'h11FFFFF0,32'hA0, 0,0, e_idle());
        row(0,0,0, 1,1,32'h11FFFFF0,32'hA0, 1,32'h5555, e_wr(32'h11FFFFF0,1,32'hA0));
        row(0,0,0, 1,1,32'h11FFFFF0,32'hA1, 1,32'h5555, e_wr(32'h11FFFFF4,1,32'hA1));
        row(0,0,0, 1,0,32'h0,       32'hA2, 1,32'h5555, e_wr(32'h11FFFFF8,1,32'hA2));
        row(0,0,0, 1,1,32'h11FFFFF0,32'hA3, 1,32'h5555, e_wr(32'h11FFFFFC,1,32'hA3));
        row(0,0,0, 0,1,32'h11FFFFF0,32'hA4, 0,0, e_done(0,1,0));
        row(0,0,0, 0,0,0,0, 0,0, e_idle());
        // Contention right after reset: D first, then I, then D again
        row(1,1,32'h200, 1,0,32'h100,0, 0,0, e_idle());
        row(0,1,32'h200, 1,0,32'h100,0, 0,0, e_idle());
        for (int k = 0; k < 4; k++)
            row(0,1,32'h200, 1,0,32'h100,0, 1,32'(32'hD0 + k), e_rd(32'(32'h100 + 4*k),1,32'(32'hD0 + k)));
        row(0,1,32'h200, 0,0,32'h100,0, 0,0, e_done(0,1,0));
        row(0,1,32'h200, 0,0,32'h100,0, 0,0, e_idle());
        for (int k = 0; k < 4; k++)
            row(0,1,32'h200, 1,0,32'h10C,0, 1,32'(32'h10 + k), e_ri(32'(32'h200 + 4*k),1,32'(32'h10 + k)));
        row(0,0,32'h200, 1,0,32'h10C,0, 0,0, e_done(1,0,0));
        row(0,1,32'h200, 1,0,32'h10C,0, 0,0, e_idle());
        // D read with a 3-cycle stall after the first beat
        row(0,1,32'h200, 1,0,32'h10C,0, 1,32'hE0, e_rd(32'h100,1,32'hE0));
        for (int k = 0; k < 3; k++)
            row(0,1,32'h200, 1,0,32'h10C,0, 0,32'hBAD, e_rd(32'h104,0,0));
        row(0,1,32'h200, 1,0,32'h10C,0, 1,32'hE1, e_rd(32'h104,1,32'hE1));
        row(0,1,32'h200, 1,0,32'h10C,0, 1,32'hE2, e_rd(32'h108,1,32'hE2));
        row(0,1,32'h200, 1,0,32'h10C,0, 1,32'hE3, e_rd(32'h10C,1,32'hE3));
        row(0,1,32'h200, 0,0,32'h10C,0, 0,0, e_done(0,1,0));
        // I read that times out after 8 silent busy cycles
        row(0,1,32'h200, 0,0,0,0, 0,0, e_idle());
        for (int k = 0; k < 8; k++)
            row(0,1,32'h200, 0,0,0,0, 0,32'hBAD, e_ri(32'h200,0,0));
        row(0,0,32'h200, 0,0,0,0, 0,0, e_done(1,0,1));
        row(0,0,0, 0,0,0,0, 0,0, e_idle());
        // Reset during beat 2 of a D read, then a fresh I read
        row(0,0,0, 1,0,32'h300,0, 0,0, e_idle());
        row(0,0,0, 1,0,32'h300,0, 1,32'hF0, e_rd(32'h300,1,32'hF0));
        row(0,0,0, 1,0,32'h300,0, 1,32'hF1, e_rd(32'h304,1,32'hF1));
        row(1,0,0, 1,0,32'h300,0, 0,0, e_rd(32'h308,0,0));
        row(0,1,32'h400, 0,0,32'h300,0, 0,0, e_idle());
        for (int k = 0; k < 4; k++)
            row(0,1,32'h400, 0,0,0,0, 1,32'(32'h55 + k), e_ri(32'(32'h400 + 4*k),1,32'(32'h55 + k)));
        row(0,0,32'h400, 0,0,0,0, 0,0, e_done(1,0,0));
        row(0,0,0, 0,0,0,0, 0,0, e_idle());

        // Initial reset
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_out("reset", observe(), e_idle());
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rst           = vecs[i].rst;
            bus.i_req     = vecs[i].i_req;
            bus.i_addr    = vecs[i].i_addr;
            bus.d_req     = vecs[i].d_req;
            bus.d_we      = vecs[i].d_we;
            bus.d_addr    = vecs[i].d_addr;
            bus.d_wdata   = vecs[i].d_wdata;
            bus.mem_ready = vecs[i].mem_ready;
            bus.mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), observe(), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Stalled I burst: ready every third cycle, unaligned address, bounded wait
        nbeat = 0;
        ndone = 0;
        nbad  = 0;
        rst = 1'b0;
        bus.i_addr = 32'h000ABC14;
        bus.i_req  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.mem_ready = (c % 3 == 2);
            bus.mem_rdata = 32'(32'hC0 + nbeat);
            if (nbeat == 4) bus.i_req = 1'b0;
            @(negedge clk);
            if (bus.i_rvalid) begin
                check32("stall_rdata", bus.i_rdata, 32'(32'hC0 + nbeat));
                check32("stall_addr", bus.mem_addr, 32'(32'h000ABC10 + 4*nbeat));
                nbeat++;
            end
            if (bus.i_done) ndone++;
            if (bus.bus_err || bus.d_rvalid || bus.d_done) nbad++;
            @(posedge clk);
            #1;
        end
        check32("stall_beats", 32'(nbeat), 32'd4);
        check32("stall_done_count", 32'(ndone), 32'd1);
        check32("stall_spurious", 32'(nbad), 32'd0);
        check_out("stall_idle", observe(), e_idle());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
